// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - state encoding, port indices and trace formatting for the DM port arbiter
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  function automatic string trace_line(input logic [31:0] pc,
                                       input logic [31:0] addr,
                                       input logic [31:0] data);
    return $sformatf("@%h: *%h <= %h", pc, addr, data);
  endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_arb2.sv
// rtl/dm_port_arbiter_rr_arb2.sv - combinational 2-way round-robin picker
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // On a tie the port that did not win last time goes next.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_CPU;
    if (req == 2'b11)
      gnt_id = ~last_grant;
    else if (req[PORT_DBG])
      gnt_id = PORT_DBG;
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - shares the DM port between CPU MEM stage and debug loader
// Optional write trace enabled by defining DM_ARB_TRACE_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [3:0]        be0,
  input  logic [31:0]       pc0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [3:0]        be1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state, state_nxt;
  logic              last_grant;
  logic              grant_id;
  logic              gnt_valid;
  logic              gnt_id;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;

  rr_arb2 u_rr_arb2 (
    .req        ({req1, req0}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = gnt_valid ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates the strobe combinationally so an interrupted write never lands.
  always_comb begin
    mem_we = (state == ACCESS) & we_q & ~reset;
    mem_be = (state == ACCESS) ? be_q : 4'h0;
    ack0   = (state == RESP) && (grant_id == PORT_CPU);
    ack1   = (state == RESP) && (grant_id == PORT_DBG);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Fields are latched only on the grant so later port changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'h0;
    end else if (state == IDLE && gnt_valid) begin
      grant_id <= gnt_id;
      if (gnt_id == PORT_DBG) begin
        we_q    <= we1;
        addr_q  <= addr1;
        wdata_q <= wdata1;
        be_q    <= be1;
      end else begin
        we_q    <= we0;
        addr_q  <= addr0;
        wdata_q <= wdata0;
        be_q    <= be0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)              last_grant <= PORT_DBG;
    else if (state == RESP) last_grant <= grant_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ACCESS && !we_q) begin
      if (grant_id == PORT_DBG) rdata1 <= mem_rdata;
      else                      rdata0 <= mem_rdata;
    end
  end

`ifdef DM_ARB_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset)
      pc_q <= 32'h0;
    else if (state == IDLE && gnt_valid)
      pc_q <= (gnt_id == PORT_CPU) ? pc0 : 32'h0;
    if (!reset && state == ACCESS && we_q)
      $display("%s", trace_line(pc_q, 32'(addr_q), 32'(wdata_q)));
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc0;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - directed self-checking bench for dm_port_arbiter
module tb_dm_port_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1, pc0;
  logic [3:0]  be0, be1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] dm [0:4095];
  int          checks = 0;
  int          errors = 0;

  dm_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .be0       (be0),
    .pc0       (pc0),
    .ack0      (ack0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .be1       (be1),
    .ack1      (ack1),
    .rdata1    (rdata1),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = dm[mem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) dm[mem_addr[13:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) dm[i] = 32'h0;
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; be0 = 4'h0; pc0 = 32'h3000;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0; be1 = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    reset = 1'b0;

    // write 0xDEADBEEF to 0x10, then change wdata0 after the grant
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF; be0 = 4'hF;
    cyc();
    chk("w_mem_we", mem_we, 1);
    chk("w_mem_addr", mem_addr, 32'h10);
    chk("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("w_mem_be", mem_be, 4'hF);
    chk("w_ack0_early", ack0, 0);
    wdata0 = 32'hFFFF_FFFF;
    #1;
    chk("w_wdata_latched", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    chk("w_ack0", ack0, 1);
    chk("w_ack1", ack1, 0);
    chk("w_resp_mem_we", mem_we, 0);
    chk("w_resp_mem_be", mem_be, 0);
    chk("w_resp_addr_hold", mem_addr, 32'h10);
    chk("w_dm", dm[4], 32'hDEAD_BEEF);
    req0 = 1'b0; we0 = 1'b0;
    cyc();
    chk("w_ack0_gone", ack0, 0);

    // read back 0x10
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    cyc();
    chk("r_mem_we", mem_we, 0);
    chk("r_ack0_early", ack0, 0);
    cyc();
    chk("r_ack0", ack0, 1);
    chk("r_rdata0", rdata0, 32'hDEAD_BEEF);
    req0 = 1'b0;
    cyc();

    // both ports held with reads straight after reset: 0,1,0,1 every 3 cycles
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    dm[64]  = 32'hA0A0_A0A0;
    dm[128] = 32'hB1B1_B1B1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100; be0 = 4'hF;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h200; be1 = 4'hF;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rr_addr", mem_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      chk("rr_noack", {ack1, ack0}, 2'b00);
      cyc();
      chk("rr_ack", {ack1, ack0}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 0) chk("rr_rdata1_untouched", rdata1, 0);
      if (k % 2 == 0) chk("rr_rdata0", rdata0, 32'hA0A0_A0A0);
      else            chk("rr_rdata1", rdata1, 32'hB1B1_B1B1);
      cyc();
      chk("rr_idle_noack", {ack1, ack0}, 2'b00);
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc();

    // port 1 alone, top of DM
    dm[4095] = 32'h1234_5678;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h3FFC;
    cyc();
    chk("p1_mem_addr", mem_addr, 32'h3FFC);
    chk("p1_ack1_early", ack1, 0);
    cyc();
    chk("p1_ack1", ack1, 1);
    chk("p1_ack0", ack0, 0);
    chk("p1_rdata1", rdata1, 32'h1234_5678);
    chk("p1_rdata0_kept", rdata0, 32'hA0A0_A0A0);
    req1 = 1'b0;
    cyc();

    // reset during the ACCESS cycle of a write to 0x20
    dm[8] = 32'h1111_2222;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h9999_9999; be0 = 4'hF;
    cyc();
    chk("ra_mem_we_pre", mem_we, 1);
    reset = 1'b1;
    #1;
    chk("ra_mem_we_gated", mem_we, 0);
    cyc();
    chk("ra_no_ack", ack0, 0);
    chk("ra_dm_kept", dm[8], 32'h1111_2222);
    chk("ra_rdata0_clr", rdata0, 0);
    chk("ra_mem_be", mem_be, 0);
    reset = 1'b0;
    cyc();
    chk("ra_regrant_we", mem_we, 1);
    chk("ra_regrant_addr", mem_addr, 32'h20);
    cyc();
    chk("ra_ack0", ack0, 1);
    chk("ra_dm_written", dm[8], 32'h9999_9999);
    req0 = 1'b0;
    cyc();

    // partial byte-enable write
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h22; wdata0 = 32'hAAAA_AAAA; be0 = 4'b0011;
    cyc();
    chk("be_mem_be", mem_be, 4'b0011);
    chk("be_addr_passthru", mem_addr, 32'h22);
    cyc();
    chk("be_ack0", ack0, 1);
    chk("be_dm", dm[8], 32'h9999_AAAA);
    req0 = 1'b0;
    cyc();
    chk("be_idle_ack", ack0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port (word-addressed, asynchronous-read, synchronous-write DM) between two requesters.
- Port 0 is the CPU MEM stage; port 1 is the debug/preload loader.
- Round-robin arbitration, a registered command stage, one memory access per grant, and a one-cycle ack pulse with registered read data.
- Sits between the MEM stage / loader and the DM instance; owns every DM control input.

Parameters:
- ADDR_W, 32, byte-address width from requesters.
- DATA_W, 32, data width; fixed at 32 (byte enables assume 4 lanes).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req0  in  1  port 0 request, held until ack0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  ADDR_W  port 0 byte address
- wdata0  in  DATA_W  port 0 write data
- be0  in  4  port 0 byte enables
- pc0  in  32  PC of the port 0 access (trace only)
- ack0  out  1  port 0 completion pulse
- rdata0  out  DATA_W  port 0 read data, valid while ack0=1
- req1, we1, addr1, wdata1, be1, ack1, rdata1: same as port 0, for port 1
- mem_we  out  1  DM write strobe
- mem_addr  out  ADDR_W  DM byte address (DM indexes [13:2])
- mem_wdata  out  DATA_W  DM write data
- mem_be  out  4  DM byte enables
- mem_rdata  in  DATA_W  DM combinational read data

Behaviour:
- Reset is synchronous, active-high, clock clk. Reset values:
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - ack0=ack1=0, rdata0=rdata1=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- FSM states:
  - IDLE: sample req0/req1 at the edge. If any is high, pick the winner, latch its we/addr/wdata/be/pc into the command registers, record grant_id, and go to ACCESS.
  - ACCESS: drive mem_* from the command registers. mem_we = we_q & ~reset. At the edge, capture mem_rdata into rdata[grant_id] (reads only; writes leave rdata unchanged). Go to RESP.
  - RESP: ack[grant_id]=1 for exactly this cycle. Set last_grant=grant_id. Go to IDLE unconditionally.
- Arbitration:
  - Only one request high: grant it.
  - Both high: grant the port != last_grant.
- Latency and throughput:
  - req sampled in cycle N; memory accessed in N+1; ack and rdata in N+2.
  - Maximum throughput is one access per 3 cycles.
- Handshake:
  - Requester holds req and all its fields stable until it sees ack.
  - Requester deasserts req at the edge that ends the ack cycle.
  - A req still high in the IDLE cycle after RESP is a new request.
- mem_* outside ACCESS: mem_we=0, mem_be=0; mem_addr and mem_wdata hold their last values.
- Same-cycle requests during ACCESS/RESP are ignored, not queued; the requesting port keeps req high.
- Fields are captured only in IDLE, so port changes after the grant do not affect the access in flight.
- Reset mid-ACCESS: no write reaches DM in that cycle; ack is not issued; state returns to IDLE.
- Address alignment: addr[1:0] is ignored for addressing and passed through on mem_addr unchanged.

Optional Feature:
- Macro: DM_ARB_TRACE_EN.
- Defined: at the ACCESS edge of every write with reset low, print "@<pc>: *<addr> <= <wdata>" in %h format. pc is pc0 for port 0 grants and 32'h0 for port 1 grants.
- Not defined: no $display; pc0 is unused.
- Logic and timing are identical either way.

Decomposition:
- Package dm_arb_pkg holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - port indices PORT_CPU=0, PORT_DBG=1;
  - the trace format string.
- One sub-module, rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_valid, gnt_id.

Test Plan:
- Reset, then req0=1, we0=1, addr0=0x0000_0010, wdata0=0xDEAD_BEEF, be0=4'hF → mem_we=1 in cycle 2 with mem_addr=0x10; ack0=1 in cycle 3; a later read of 0x10 returns rdata0=0xDEAD_BEEF with ack0.
- req0 and req1 both held high with reads, starting right after reset → grants alternate 0,1,0,1; each ack arrives 3 cycles after the previous one.
- req1 alone, read of addr 0x0000_3FFC holding 0x1234_5678 → ack1 at N+2 with rdata1=0x1234_5678; rdata0 unchanged.
- Change wdata0 to 0xFFFF_FFFF after the IDLE-edge capture → DM receives the originally latched 0xDEAD_BEEF.
- Assert reset during ACCESS of a write to 0x20 → mem_we=0 that cycle; no ack; state=IDLE; DM[0x20] keeps its old value.
- With DM_ARB_TRACE_EN defined, write from pc0=0x0000_3000 to 0x8 of 0x5 → log line "@00003000: *00000008 <= 00000005"; with the macro undefined, no output.
